// File: rtl/shift_ctrl_pkg.sv
// Shared types for the 16-bit shift register controller.
//   op_e    : shift operation encoding (matches req_op)
//   state_e : controller FSM states
//   WIDTH_DEF : default datapath width
package shift_ctrl_pkg;

  localparam int WIDTH_DEF = 16;

  typedef enum logic [1:0] {
    OP_SLL = 2'b00,
    OP_SRL = 2'b01,
    OP_SRA = 2'b10,
    OP_ROR = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_SHIFT = 2'b01,
    S_DONE  = 2'b10
  } state_e;

endpackage

// File: rtl/shift_step.sv
// One combinational shift step of the controller datapath.
//   cur   in  WIDTH  current register value
//   op    in  op_e   SLL / SRL / SRA / ROR
//   step4 in  1      0: move one position, 1: move four positions
//   nxt   out WIDTH  register value after the step
// Requires WIDTH >= 5.
module shift_step
  import shift_ctrl_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic [WIDTH-1:0] cur,
  input  op_e              op,
  input  logic             step4,
  output logic [WIDTH-1:0] nxt
);

  always_comb begin
    nxt = cur;
    case (op)
      OP_SLL: nxt = step4 ? {cur[WIDTH-5:0], 4'b0000}        : {cur[WIDTH-2:0], 1'b0};
      OP_SRL: nxt = step4 ? {4'b0000, cur[WIDTH-1:4]}        : {1'b0, cur[WIDTH-1:1]};
      OP_SRA: nxt = step4 ? {{4{cur[WIDTH-1]}}, cur[WIDTH-1:4]} : {cur[WIDTH-1], cur[WIDTH-1:1]};
      OP_ROR: nxt = step4 ? {cur[3:0], cur[WIDTH-1:4]}       : {cur[0], cur[WIDTH-1:1]};
      default: nxt = cur;
    endcase
  end

endmodule

// File: rtl/shift_reg16_ctrl.sv
// Sequencing controller for the 16-bit shift register datapath.
// Accepts one command per req handshake, steps the register in SHIFT,
// presents the result in DONE until the rsp handshake.
//   clk, rst_n            clock, async active-low reset
//   req_valid/req_ready   command handshake; req_data, req_amt, req_op
//   rsp_valid/rsp_ready   result handshake; rsp_data
//   flush                 synchronous abort to IDLE (highest priority)
//   busy                  high in SHIFT or DONE
// Optional macro SHIFT_CTRL_FAST_EN: move four positions per cycle while
// the remaining count is at least four; results are unchanged.
module shift_reg16_ctrl
  import shift_ctrl_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int AMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_data,
  input  logic [AMT_W-1:0] req_amt,
  input  logic [1:0]       req_op,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  input  logic             flush,
  output logic             busy
);

  state_e           state;
  op_e              op;
  logic [WIDTH-1:0] sreg, sreg_nxt;
  logic [AMT_W-1:0] cnt, step;
  logic             step4;

`ifdef SHIFT_CTRL_FAST_EN
  assign step4 = (cnt >= AMT_W'(4));
`else
  assign step4 = 1'b0;
`endif

  assign step = step4 ? AMT_W'(4) : AMT_W'(1);

  shift_step #(.WIDTH(WIDTH)) u_step (
    .cur   (sreg),
    .op    (op),
    .step4 (step4),
    .nxt   (sreg_nxt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      sreg  <= '0;
      cnt   <= '0;
      op    <= OP_SLL;
    end else if (flush) begin
      // Abort: register contents are kept, only control is cleared.
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        S_IDLE: if (req_valid) begin
          sreg  <= req_data;
          op    <= op_e'(req_op);
          cnt   <= req_amt;
          state <= (req_amt != '0) ? S_SHIFT : S_DONE;
        end
        S_SHIFT: begin
          sreg <= sreg_nxt;
          cnt  <= cnt - step;
          // Leave on the same edge the count reaches zero.
          if (cnt == step) state <= S_DONE;
        end
        S_DONE: if (rsp_ready) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Outputs decode straight from flops; no combinational input paths.
  assign req_ready = (state == S_IDLE);
  assign rsp_valid = (state == S_DONE);
  assign busy      = (state != S_IDLE);
  assign rsp_data  = rsp_valid ? sreg : '0;

endmodule

// File: tb/tb_shift_reg16_ctrl.sv
// Directed bench for shift_reg16_ctrl: hand-computed results and latencies.
module tb_shift_reg16_ctrl;
  import shift_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [15:0] req_data = '0;
  logic [3:0]  req_amt = '0;
  logic [1:0]  req_op = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [15:0] rsp_data;
  logic        flush = 1'b0;
  logic        busy;

  int n_vec = 0;
  int n_err = 0;

  shift_reg16_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_data(req_data), .req_amt(req_amt), .req_op(req_op),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .flush(flush), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int exp_lat(input int a);
`ifdef SHIFT_CTRL_FAST_EN
    return a / 4 + a % 4 + 1;
`else
    return a + 1;
`endif
  endfunction

  // Present a command; returns after the accepting edge (+1).
  task automatic send(input string tag, input logic [15:0] d, input logic [3:0] a, input logic [1:0] op);
    @(negedge clk);
    req_valid = 1'b1; req_data = d; req_amt = a; req_op = op;
    chk({tag, "_req_ready"}, 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0; req_data = 16'hDEAD; req_amt = 4'hF; req_op = 2'b11;
  endtask

  // Count edges from the accepting edge (inclusive) until rsp_valid.
  task automatic wait_rsp(input string tag, output int lat);
    logic busy_ok;
    busy_ok = busy;
    lat = 1;
    while (!rsp_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      busy_ok &= busy;
    end
    chk({tag, "_busy"}, 32'(busy_ok), 32'd1);
  endtask

  task automatic do_cmd(input string tag, input logic [15:0] d, input logic [3:0] a,
                        input logic [1:0] op, input logic [15:0] exp_d);
    int lat;
    send(tag, d, a, op);
    wait_rsp(tag, lat);
    chk({tag, "_lat"}, 32'(lat), 32'(exp_lat(int'(a))));
    chk({tag, "_data"}, 32'(rsp_data), 32'(exp_d));
    @(posedge clk); #1;  // rsp_ready=1 completes the handshake here
    chk({tag, "_idle"}, {30'd0, req_ready, rsp_valid}, 32'b10);
  endtask

  initial begin
    int lat;
    // Reset state
    #12;
    chk("rst_outs", {28'd0, req_ready, rsp_valid, busy, 1'b0}, 32'b1000);
    chk("rst_data", 32'(rsp_data), 32'h0);
    @(negedge clk); rst_n = 1'b1;

    do_cmd("sll15", 16'h0001, 4'd15, 2'b00, 16'h8000);
    do_cmd("sra4",  16'h8000, 4'd4,  2'b10, 16'hF800);
    do_cmd("srl4",  16'h8000, 4'd4,  2'b01, 16'h0800);
    do_cmd("ror4",  16'h1234, 4'd4,  2'b11, 16'h4123);
    do_cmd("amt0",  16'hA5A5, 4'd0,  2'b00, 16'hA5A5);
    do_cmd("ror15", 16'h0001, 4'd15, 2'b11, 16'h0002);
    do_cmd("srl15", 16'hFFFF, 4'd15, 2'b01, 16'h0001);
    do_cmd("sra15p",16'h4000, 4'd15, 2'b10, 16'h0000);
    do_cmd("sra7n", 16'h9000, 4'd7,  2'b10, 16'hFF20);
    do_cmd("sll5",  16'h0F0F, 4'd5,  2'b00, 16'hE1E0);

    // Backpressure: result held, new commands refused until handshake.
    rsp_ready = 1'b0;
    send("stall", 16'h00F0, 4'd2, 2'b00);
    wait_rsp("stall", lat);
    chk("stall_lat", 32'(lat), 32'(exp_lat(2)));
    @(negedge clk);
    req_valid = 1'b1; req_data = 16'h5555; req_amt = 4'd0; req_op = 2'b00;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("stall_hold", {13'd0, req_ready, rsp_valid, rsp_data}, {13'd0, 1'b0, 1'b1, 16'h03C0});
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    chk("stall_release", {30'd0, req_ready, rsp_valid}, 32'b10);

    // Async reset in the middle of SHIFT.
    send("rstmid", 16'h0001, 4'd15, 2'b00);
    repeat (4) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("rstmid_outs", {28'd0, req_ready, rsp_valid, busy, 1'b0}, 32'b1000);
    chk("rstmid_data", 32'(rsp_data), 32'h0);
    @(negedge clk); rst_n = 1'b1;
    do_cmd("post_rst", 16'h1234, 4'd4, 2'b11, 16'h4123);

    // Flush in SHIFT together with a new request.
    send("flush", 16'h0003, 4'd15, 2'b00);
    repeat (2) @(posedge clk);
    @(negedge clk);
    flush = 1'b1; req_valid = 1'b1; req_data = 16'hFFFF; req_amt = 4'd0;
    @(posedge clk); #1;
    chk("flush_idle", {29'd0, req_ready, rsp_valid, busy}, 32'b100);
    flush = 1'b0; req_valid = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      chk("flush_noacc", {29'd0, req_ready, rsp_valid, busy}, 32'b100);
    end
    do_cmd("post_flush", 16'h8001, 4'd1, 2'b11, 16'hC000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
